// File: rtl/tdc_phase_decoder_lf.sv
// Decodes each new TDC measurement into a signed phase error and drives a PI loop filter.
// Registered path: capture, decode, integrate+output. word_valid arrives 3 cycles after the sampled edge.
module tdc_phase_decoder_lf #(
  parameter int DCO_W    = 10,
  parameter int CENTER   = 512,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 4,
  parameter int ACC_W    = 20,
  parameter int LOCK_THR = 16,
  parameter int LOCK_CNT = 8
) (
  input  logic               dco_clk,
  input  logic               reset,
  input  logic               loop_enable,
  input  logic               fine_done_pre,
  input  logic               early,
  input  logic [4:0]         counter_rise,
  input  logic [4:0]         counter_fall,
  input  logic [7:0]         bs,
  input  logic [8:0]         vernier,
  output logic signed [11:0] phase_err,
  output logic [DCO_W-1:0]   dco_word,
  output logic               word_valid,
  output logic               decode_err,
  output logic               locked
);
  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam longint ACC_MAX_L  = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint WORD_MAX_L = (longint'(1) << DCO_W) - 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX  = ACC_MAX_L[SUM_W-1:0];
  localparam logic signed [SUM_W-1:0] ACC_MIN  = -ACC_MAX;
  localparam logic signed [SUM_W-1:0] WORD_MAX = WORD_MAX_L[SUM_W-1:0];
  localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER);

  logic                     r_fdp_d;
  logic                     r_s0_vld;
  logic                     r_s0_early;
  logic [4:0]               r_s0_rise;
  logic [4:0]               r_s0_fall;
  logic [7:0]               r_s0_bs;
  logic [8:0]               r_s0_vern;
  logic                     r_s1_vld;
  logic signed [11:0]       r_s1_err;
  logic                     r_decode_err;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [11:0]       r_phase_err;
  logic [DCO_W-1:0]         r_dco_word;
  logic                     r_word_valid;

  logic                     w_start;
  logic [2:0]               w_m;
  logic                     w_m_ok;
  logic [2:0]               w_f;
  logic                     w_f_ok;
  logic                     w_cons;
  logic                     w_ok;
  logic [10:0]              w_mag;
  logic signed [11:0]       w_err;
  logic signed [SUM_W-1:0]  w_err_ext;
  logic signed [SUM_W-1:0]  w_acc_ext;
  logic signed [SUM_W-1:0]  w_acc_sum;
  logic signed [SUM_W-1:0]  w_acc_new;
  logic signed [SUM_W-1:0]  w_word_sum;
  logic [DCO_W-1:0]         w_word_clamped;
  logic [11:0]              w_abs_err;
  logic                     w_in_lock;
  logic [CNT_W-1:0]         w_cnt_next;

  // History resets to 1 so a level already high at reset release is not a new sample.
  assign w_start = fine_done_pre & ~r_fdp_d;

  always_ff @(posedge dco_clk) begin
    if (reset) begin
      r_fdp_d  <= 1'b1;
      r_s0_vld <= 1'b0;
    end else begin
      r_fdp_d  <= fine_done_pre;
      r_s0_vld <= w_start;
    end
  end

  always_ff @(posedge dco_clk) begin
    if (w_start) begin
      r_s0_early <= early;
      r_s0_rise  <= counter_rise;
      r_s0_fall  <= counter_fall;
      r_s0_bs    <= bs;
      r_s0_vern  <= vernier;
    end
  end

  always_comb begin
    w_m    = 3'd0;
    w_m_ok = 1'b1;
    case (r_s0_bs)
      8'h01, 8'h80: w_m = 3'd0;
      8'h04:        w_m = 3'd1;
      8'h10:        w_m = 3'd2;
      8'h40:        w_m = 3'd3;
      8'h02:        w_m = 3'd4;
      8'h08:        w_m = 3'd5;
      8'h20:        w_m = 3'd6;
      default:      w_m_ok = 1'b0;
    endcase
    w_f    = 3'd0;
    w_f_ok = 1'b1;
    case (r_s0_vern)
      9'b000000111: w_f = 3'd0;
      9'b111111110: w_f = 3'd1;
      9'b111111100: w_f = 3'd2;
      9'b111111000: w_f = 3'd3;
      9'b111110000: w_f = 3'd4;
      9'b111100000: w_f = 3'd5;
      9'b111000000: w_f = 3'd6;
      9'b110000000,
      9'b100000000: w_f = 3'd7;
      default:      w_f_ok = 1'b0;
    endcase
  end

  // Compared 6 bits wide so rise=31 never aliases fall=0.
  assign w_cons = ({1'b0, r_s0_fall} == {1'b0, r_s0_rise}) ||
                  ({1'b0, r_s0_fall} == ({1'b0, r_s0_rise} + 6'd1));
  assign w_ok   = w_m_ok & w_f_ok & w_cons;
  assign w_mag  = {r_s0_rise, 6'd0} + {5'd0, w_m, 3'd0} + {8'd0, w_f};
  assign w_err  = r_s0_early ? $signed({1'b0, w_mag}) : -$signed({1'b0, w_mag});

  always_ff @(posedge dco_clk) begin
    if (reset) begin
      r_s1_vld     <= 1'b0;
      r_decode_err <= 1'b0;
      r_s1_err     <= '0;
    end else begin
      r_s1_vld     <= r_s0_vld & w_ok;
      r_decode_err <= r_s0_vld & ~w_ok;
      if (r_s0_vld & w_ok)
        r_s1_err <= w_err;
    end
  end

  assign w_err_ext = {{(SUM_W-12){r_s1_err[11]}}, r_s1_err};
  assign w_acc_ext = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_acc_sum = w_acc_ext + w_err_ext;
  assign w_word_sum = CENTER_S + (w_err_ext >>> KP_SHIFT) + (w_acc_new >>> KI_SHIFT);

  always_comb begin
    w_acc_new = w_acc_sum;
    if (w_acc_sum > ACC_MAX)
      w_acc_new = ACC_MAX;
    else if (w_acc_sum < ACC_MIN)
      w_acc_new = ACC_MIN;
    w_word_clamped = w_word_sum[DCO_W-1:0];
    if (w_word_sum[SUM_W-1])
      w_word_clamped = '0;
    else if (w_word_sum > WORD_MAX)
      w_word_clamped = '1;
    w_abs_err  = r_s1_err[11] ? -r_s1_err : r_s1_err;
    w_in_lock  = (w_abs_err <= 12'(LOCK_THR));
    w_cnt_next = '0;
    if (w_in_lock)
      w_cnt_next = (r_cnt == CNT_W'(LOCK_CNT)) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge dco_clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_phase_err  <= '0;
      r_dco_word   <= DCO_W'(CENTER);
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_phase_err <= r_s1_err;
        if (loop_enable) begin
          r_acc      <= w_acc_new[ACC_W-1:0];
          r_dco_word <= w_word_clamped;
          r_cnt      <= w_cnt_next;
        end else begin
          r_dco_word <= DCO_W'(CENTER);
        end
      end
      if (r_decode_err || !loop_enable)
        r_cnt <= '0;
      if (!loop_enable)
        r_acc <= '0;
    end
  end

  assign phase_err  = r_phase_err;
  assign dco_word   = r_dco_word;
  assign word_valid = r_word_valid;
  assign decode_err = r_decode_err;
  assign locked     = (r_cnt == CNT_W'(LOCK_CNT));
endmodule

// File: tb/tb_tdc_phase_decoder_lf.sv
// Bench for tdc_phase_decoder_lf: directed corners plus random samples, scored against
// an arithmetic reference model through expected-response queues.
`timescale 1ns/1ps
module tb_tdc_phase_decoder_lf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic le = 1'b1;
  logic fdp = 1'b1;
  logic early = 1'b0;
  logic [4:0] rise = '0;
  logic [4:0] fall = '0;
  logic [7:0] bs = '0;
  logic [8:0] vern = '0;
  logic signed [11:0] phase_err;
  logic [9:0] dco_word;
  logic word_valid, decode_err, locked;

  always #5 clk = ~clk;

  tdc_phase_decoder_lf dut (
    .dco_clk(clk), .reset(reset), .loop_enable(le), .fine_done_pre(fdp), .early(early),
    .counter_rise(rise), .counter_fall(fall), .bs(bs), .vernier(vern),
    .phase_err(phase_err), .dco_word(dco_word), .word_valid(word_valid),
    .decode_err(decode_err), .locked(locked)
  );

  typedef struct { int cyc; int perr; int word; int lck; } good_t;
  typedef struct { int cyc; int word; } bad_t;

  good_t good_q[$];
  bad_t  bad_q[$];
  int cyc = 0;
  int rd_good = 0, rd_bad = 0;
  int vectors = 0, miscompares = 0;
  int tmo = 0;
  bit rst_req = 0, fin_req = 0, fin_ack = 0, lock_pend = 0;
  int m_acc = 0, m_cnt = 0, m_word = 512;
  good_t g;
  bad_t b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (lock_pend) begin
      lock_pend = 0;
      chk("locked_after_reject", int'(locked), 0);
    end
    if (rst_req) begin
      chk("rst_dco_word", int'(dco_word), 512);
      chk("rst_phase_err", int'(phase_err), 0);
      chk("rst_word_valid", int'(word_valid), 0);
      chk("rst_decode_err", int'(decode_err), 0);
      chk("rst_locked", int'(locked), 0);
    end
    if (word_valid) begin
      if (rd_good >= good_q.size()) begin
        vectors++; miscompares++;
        $display("FAIL spurious_word_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        g = good_q[rd_good];
        rd_good++;
        chk("word_latency", cyc, g.cyc);
        chk("phase_err", int'(phase_err), g.perr);
        chk("dco_word", int'(dco_word), g.word);
        chk("locked", int'(locked), g.lck);
      end
    end
    if (decode_err) begin
      if (rd_bad >= bad_q.size()) begin
        vectors++; miscompares++;
        $display("FAIL spurious_decode_err: got pulse at cycle %0d, expected none", cyc);
      end else begin
        b = bad_q[rd_bad];
        rd_bad++;
        chk("decode_err_latency", cyc, b.cyc);
        chk("dco_word_held", int'(dco_word), b.word);
        lock_pend = 1;
      end
    end
    if (fin_req && !fin_ack) begin
      chk("timeouts", tmo, 0);
      chk("words_outstanding", good_q.size() - rd_good, 0);
      chk("rejects_outstanding", bad_q.size() - rd_bad, 0);
      fin_ack = 1;
    end
  end

  function automatic int floordiv(input int x, input int d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic int dec_m(input logic [7:0] bv);
    int mt [8] = '{0, 4, 1, 5, 2, 6, 3, 0};
    if ($countones(bv) != 1) return -1;
    for (int p = 0; p < 8; p++) if (bv[p]) return mt[p];
    return -1;
  endfunction

  function automatic int dec_f(input logic [8:0] v);
    logic [8:0] pat;
    if (v == 9'b000000111) return 0;
    for (int k = 1; k <= 8; k++) begin
      pat = 9'h1FF << k;
      if (v == pat) return (k > 7) ? 7 : k;
    end
    return -1;
  endfunction

  task automatic send(input bit e, input int r, input int f, input int bv, input int v,
                      input int hi, input int lo);
    int m, fi, err, s, w;
    bit ok;
    m  = dec_m(bv[7:0]);
    fi = dec_f(v[8:0]);
    ok = (m >= 0) && (fi >= 0) && (f == r || f == r + 1);
    @(posedge clk); #1;
    early = e; rise = r[4:0]; fall = f[4:0]; bs = bv[7:0]; vern = v[8:0]; fdp = 1'b1;
    if (ok) begin
      err = r * 64 + m * 8 + fi;
      if (!e) err = -err;
      if (le) begin
        s = m_acc + err;
        if (s > 524287) s = 524287;
        if (s < -524287) s = -524287;
        m_acc = s;
        w = 512 + floordiv(err, 4) + floordiv(m_acc, 16);
        m_word = (w < 0) ? 0 : (w > 1023) ? 1023 : w;
        m_cnt = (err <= 16 && err >= -16) ? ((m_cnt < 8) ? m_cnt + 1 : 8) : 0;
      end else begin
        m_acc = 0; m_cnt = 0; m_word = 512;
      end
      good_q.push_back('{cyc: cyc + 3, perr: err, word: m_word, lck: int'(m_cnt == 8)});
    end else begin
      m_cnt = 0;
      bad_q.push_back('{cyc: cyc + 2, word: m_word});
    end
    repeat (hi - 1) begin
      @(posedge clk); #1;
      rise = 5'($urandom); fall = 5'($urandom); bs = 8'($urandom); vern = 9'($urandom);
      early = 1'($urandom);
    end
    @(posedge clk); #1;
    fdp = 1'b0;
    repeat (lo - 1) @(posedge clk);
  endtask

  task automatic rand_sample(input int hi, input int lo);
    int r, f, bv, v, k, kind;
    kind = $urandom_range(9);
    r  = (kind < 4) ? $urandom_range(1) : $urandom_range(31);
    f  = (r < 31 && $urandom_range(1) == 1) ? r + 1 : r;
    bv = (kind < 2) ? 1 : (1 << $urandom_range(7));
    k  = $urandom_range(8);
    v  = (k == 0) ? 7 : ((32'h1FF << k) & 32'h1FF);
    if (kind == 9) begin
      case ($urandom_range(2))
        0:       bv = $urandom_range(255);
        1:       v = $urandom_range(511);
        default: f = (r + 2) % 32;
      endcase
    end
    send(1'($urandom_range(1)), r, f, bv, v, hi, lo);
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_good < good_q.size() || rd_bad < bad_q.size()) && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (n >= 30) tmo++;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    drain();
    @(posedge clk); #1;
    reset = 1'b1; fdp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_acc = 0; m_cnt = 0; m_word = 512;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 rst_req = 1;
    @(posedge clk); #1 rst_req = 0;
    repeat (4) @(posedge clk);
    #1 fdp = 1'b0;

    send(1, 3, 3, 'h10, 'b111111000, 3, 1);
    do_reset();
    send(0, 3, 3, 'h10, 'b111111000, 3, 1);
    do_reset();

    repeat (8) send(1, 0, 0, 'h01, 'b111111100, 3, 1);
    send(1, 1, 1, 'h01, 'b000000111, 3, 1);
    repeat (8) send(1, 0, 0, 'h01, 'b111111100, 3, 1);
    send(1, 3, 3, 'h03, 'b111111000, 3, 1);
    repeat (8) send(0, 0, 1, 'h01, 'b111111100, 3, 1);
    send(1, 3, 3, 'h10, 'b101010101, 3, 1);
    send(1, 4, 6, 'h10, 'b111111000, 3, 1);
    drain();

    @(posedge clk); #1;
    early = 1'b1; rise = 5'd3; fall = 5'd3; bs = 8'h10; vern = 9'b111111000; fdp = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; fdp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_acc = 0; m_cnt = 0; m_word = 512;
    repeat (6) @(posedge clk);

    repeat (300) send(1, 31, 31, 'h20, 'b110000000, 3, 1);
    repeat (270) send(0, 31, 31, 'h20, 'b110000000, 3, 1);
    do_reset();

    repeat (40) rand_sample(1, 1);
    for (int blk = 0; blk < 6; blk++) begin
      drain();
      le = (blk != 2 && blk != 4);
      if (!le) begin m_acc = 0; m_cnt = 0; end
      repeat (60) rand_sample($urandom_range(3, 1), $urandom_range(2, 1));
    end
    drain();

    fin_req = 1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(posedge clk);
    if (!fin_ack) begin
      vectors++; miscompares++;
      $display("FAIL final_check: got no completion, expected monitor summary");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
